// File: rtl/cblock_cfg_pkg.sv
// Shared state type and frame layout for the connection-block configuration loader.
package cblock_cfg_pkg;

    typedef enum logic [2:0] {IDLE, SHIFT, SETUP, WRITE, HOLD} cfg_state_t;

    localparam int unsigned CB_FRAME_W = 18;

    // Sblock-side bit groups inside one frame, for bitstream tooling.
    localparam int unsigned FLD_V_HI  = 17;
    localparam int unsigned FLD_V_LO  = 12;
    localparam int unsigned FLD_LU_HI = 11;
    localparam int unsigned FLD_LU_LO = 9;
    localparam int unsigned FLD_DR_HI = 8;
    localparam int unsigned FLD_DR_LO = 6;
    localparam int unsigned FLD_UR_HI = 5;
    localparam int unsigned FLD_UR_LO = 3;
    localparam int unsigned FLD_LD_HI = 2;
    localparam int unsigned FLD_LD_LO = 0;

endpackage

// File: rtl/cblock_cfg_loader_shift_reg.sv
// Serial-in frame register with bit counter; optional even-parity accumulator
// when CFG_PARITY_EN is defined (one trailing parity bit per frame).
module cfg_shift_reg
    import cblock_cfg_pkg::*;
#(
    parameter int unsigned FRAME_W = CB_FRAME_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_i,
    output logic [FRAME_W-1:0] frame,
    output logic               last,
    output logic               parity_ok
);

`ifdef CFG_PARITY_EN
    localparam int unsigned NUM_BITS = FRAME_W + 1;
    localparam int unsigned SR_W     = FRAME_W;
`else
    localparam int unsigned NUM_BITS = FRAME_W;
    // The final bit is taken straight from bit_i, so only FRAME_W-1 bits are stored.
    localparam int unsigned SR_W     = FRAME_W - 1;
`endif
    localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);

    logic [SR_W-1:0]  shift_q;
    logic [CNT_W-1:0] cnt_q;

    assign last = shift_en && (cnt_q == CNT_W'(NUM_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
`ifdef CFG_PARITY_EN
            if (cnt_q < CNT_W'(FRAME_W)) shift_q <= SR_W'({shift_q, bit_i});
`else
            shift_q <= SR_W'({shift_q, bit_i});
`endif
        end
    end

`ifdef CFG_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            par_q <= 1'b0;
        end else if (shift_en) begin
            par_q <= last ? 1'b0 : (par_q ^ bit_i);
        end
    end

    assign frame     = shift_q;
    assign parity_ok = ~(par_q ^ bit_i);
`else
    assign frame     = {shift_q, bit_i};
    assign parity_ok = 1'b1;
`endif

endmodule

// File: rtl/cblock_cfg_loader.sv
// Bit-serial configuration loader for the connection-block tiles.
// Optional per-frame even parity check enabled by defining CFG_PARITY_EN.
module cblock_cfg_loader
    import cblock_cfg_pkg::*;
#(
    parameter int unsigned FRAME_W   = CB_FRAME_W,
    parameter int unsigned NUM_TILES = 4,
    parameter int unsigned WR_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         bit_i,
    input  logic                         bit_valid,
    output logic                         bit_ready,
    output logic [FRAME_W-1:0]           cfg_bits,
    output logic [NUM_TILES-1:0]         wr_en,
    output logic [$clog2(NUM_TILES)-1:0] tile_idx,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned TILE_W = $clog2(NUM_TILES);
    localparam int unsigned WCNT_W = $clog2(WR_CYCLES + 1);

    cfg_state_t         state_q, state_n;
    logic [WCNT_W-1:0]  wr_cnt_q;
    logic [FRAME_W-1:0] frame;
    logic               shift_en, frame_last, parity_ok;
    logic               session_start, next_tile, load_cfg, frame_err, finish;
    logic               last_tile, wr_last;

    assign bit_ready = (state_q == SHIFT);
    assign busy      = (state_q != IDLE);
    assign shift_en  = bit_valid && bit_ready;
    assign last_tile = (tile_idx == TILE_W'(NUM_TILES - 1));
    assign wr_last   = (wr_cnt_q == WCNT_W'(WR_CYCLES - 1));

    cfg_shift_reg #(
        .FRAME_W(FRAME_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clear    (session_start || next_tile),
        .shift_en (shift_en),
        .bit_i    (bit_i),
        .frame    (frame),
        .last     (frame_last),
        .parity_ok(parity_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n       = state_q;
        session_start = 1'b0;
        next_tile     = 1'b0;
        load_cfg      = 1'b0;
        frame_err     = 1'b0;
        finish        = 1'b0;
        case (state_q)
            // done is high only in the first IDLE cycle after a session; start is dropped there.
            IDLE: if (start && !done) begin
                state_n       = SHIFT;
                session_start = 1'b1;
            end
            SHIFT: if (frame_last) begin
                if (parity_ok) begin
                    state_n  = SETUP;
                    load_cfg = 1'b1;
                end else begin
                    state_n   = IDLE;
                    frame_err = 1'b1;
                end
            end
            SETUP: state_n = WRITE;
            WRITE: if (wr_last) state_n = HOLD;
            HOLD: if (last_tile) begin
                state_n = IDLE;
                finish  = 1'b1;
            end else begin
                state_n   = SHIFT;
                next_tile = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        wr_en = '0;
        if (state_q == WRITE) wr_en[tile_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_idx <= '0;
            wr_cnt_q <= '0;
            cfg_bits <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done     <= finish;
            wr_cnt_q <= (state_q == WRITE) ? wr_cnt_q + WCNT_W'(1) : '0;
            if (session_start) begin
                tile_idx <= '0;
                err      <= 1'b0;
            end else if (next_tile) begin
                tile_idx <= tile_idx + TILE_W'(1);
            end
            if (frame_err) err <= 1'b1;
            // Loaded on entry to SETUP so the bus settles a full cycle before wr_en opens.
            if (load_cfg) cfg_bits <= frame;
        end
    end

endmodule

// File: tb/tb_cblock_cfg_loader.sv
// Self-checking bench for cblock_cfg_loader: timeline model plus directed sessions.
module tb_cblock_cfg_loader;

    localparam int FW = 18;
    localparam int NT = 4;
    localparam int WR = 2;
`ifdef CFG_PARITY_EN
    localparam int NB  = FW + 1;
    localparam bit PAR = 1'b1;
    localparam int SESSION_CYC = 92;
`else
    localparam int NB  = FW;
    localparam bit PAR = 1'b0;
    localparam int SESSION_CYC = 88;
`endif

    logic          clk = 1'b0;
    logic          rst, start, bit_i, bit_valid;
    logic          bit_ready, busy, done, err;
    logic [FW-1:0] cfg_bits;
    logic [NT-1:0] wr_en;
    logic [1:0]    tile_idx;

    always #5 clk = ~clk;

    cblock_cfg_loader #(
        .FRAME_W  (FW),
        .NUM_TILES(NT),
        .WR_CYCLES(WR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bit_i    (bit_i),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .cfg_bits (cfg_bits),
        .wr_en    (wr_en),
        .tile_idx (tile_idx),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a session is a sequence of frames; "since" counts cycles after the
    // last bit of a frame (1 = setup, 2..WR+1 = write window, WR+2 = hold).
    int m_act, m_tile, m_since, m_nbits, m_acc, m_par, m_cfg, m_err, m_done;
    int prev_done;
    int cyc = 0;

    initial begin
        m_act = 0; m_tile = 0; m_since = 0; m_nbits = 0; m_acc = 0;
        m_par = 0; m_cfg = 0; m_err = 0; m_done = 0;
        forever begin
            @(posedge clk);
            cyc++;
            prev_done = m_done;
            m_done = 0;
            if (rst) begin
                m_act = 0; m_tile = 0; m_since = 0; m_nbits = 0;
                m_acc = 0; m_par = 0; m_cfg = 0; m_err = 0;
            end else if (m_act == 0) begin
                if (start && prev_done == 0) begin
                    m_act = 1; m_tile = 0; m_since = 0; m_nbits = 0;
                    m_acc = 0; m_par = 0; m_err = 0;
                end
            end else if (m_since == 0) begin
                if (bit_valid) begin
                    if (m_nbits < FW) m_acc = (m_acc << 1) | int'(bit_i);
                    m_par = m_par ^ int'(bit_i);
                    m_nbits++;
                    if (m_nbits == NB) begin
                        if (!PAR || m_par == 0) begin
                            m_cfg = m_acc;
                            m_since = 1;
                        end else begin
                            m_act = 0;
                            m_err = 1;
                        end
                        m_nbits = 0; m_acc = 0; m_par = 0;
                    end
                end
            end else if (m_since < WR + 2) begin
                m_since++;
            end else if (m_tile == NT - 1) begin
                m_act = 0;
                m_done = 1;
            end else begin
                m_tile++;
                m_since = 0;
            end
        end
    end

    function automatic logic [NT-1:0] exp_wr();
        if (m_act != 0 && m_since >= 2 && m_since <= WR + 1) return NT'(1 << m_tile);
        return '0;
    endfunction

    // Per-session observations of the DUT, checked against literals after each session.
    int            rec_cnt[NT];
    logic [FW-1:0] rec_cfg[NT];
    int            tq[$];
    int            last_t, n_done, done_cyc, first_cyc;
    bit            want_first;
    logic [NT-1:0] prev_wr = '0;
    logic [FW-1:0] prev_cfg = '0;

    task automatic clear_rec();
        for (int i = 0; i < NT; i++) begin
            rec_cnt[i] = 0;
            rec_cfg[i] = '0;
        end
        tq.delete();
        last_t = -1; n_done = 0; done_cyc = -1; first_cyc = -1; want_first = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("busy", busy, m_act);
                chk("bit_ready", bit_ready, (m_act != 0 && m_since == 0));
                chk("wr_en", wr_en, exp_wr());
                chk("cfg_bits", cfg_bits, m_cfg);
                chk("tile_idx", tile_idx, m_tile);
                chk("done", done, m_done);
                chk("err", err, m_err);
                chk("onehot", ($countones(wr_en) <= 1), 1);
                if (wr_en != 0 && prev_wr != 0) chk("cfg_stable", cfg_bits, prev_cfg);
                prev_wr = wr_en;
                prev_cfg = cfg_bits;
                for (int i = 0; i < NT; i++) begin
                    if (wr_en[i]) begin
                        rec_cnt[i]++;
                        rec_cfg[i] = cfg_bits;
                    end
                end
                if (busy && int'(tile_idx) != last_t) begin
                    tq.push_back(int'(tile_idx));
                    last_t = int'(tile_idx);
                end
                if (done) begin
                    n_done++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                if (want_first && bit_valid && bit_ready) begin
                    first_cyc = cyc;
                    want_first = 1'b0;
                end
            end
        end
    end

    logic [FW-1:0] frames[NT];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [FW:0] word, input int n, input bit stall, input bit pulse_start);
        int  i = n - 1;
        int  guard = 0;
        bit  phase = 1'b0;
        bit  rdy;
        while (i >= 0 && guard < 2000) begin
            start = pulse_start && guard == 0;
            if (stall && phase) begin
                bit_valid = 1'b0;
            end else begin
                bit_valid = 1'b1;
                bit_i = word[i];
            end
            phase = ~phase;
            rdy = bit_ready;
            step();
            if (bit_valid && rdy) i--;
            guard++;
        end
        bit_valid = 1'b0;
        start = 1'b0;
        if (i >= 0) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got %0d bits left expected 0", i + 1);
        end
    endtask

    task automatic run_session(input bit stall, input int mid_start_tile, input int bad_tile);
        logic [FW:0] word;
        logic        p;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < NT; t++) begin
            p = (^frames[t]) ^ (t == bad_tile);
            word = PAR ? {frames[t], p} : {1'b0, frames[t]};
            send_bits(word, NB, stall, t == mid_start_tile);
            if (t == bad_tile) break;
        end
    endtask

    task automatic wait_done(input bit start_on_done);
        int k;
        for (k = 0; k < 200; k++) begin
            if (done) begin
                start = start_on_done;
                step();
                start = 1'b0;
                break;
            end
            step();
        end
        if (k == 200) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    task automatic check_frames(input string tag);
        for (int t = 0; t < NT; t++) begin
            chk({tag, "_wr_cycles"}, rec_cnt[t], WR);
            chk({tag, "_frame"}, rec_cfg[t], frames[t]);
        end
        chk({tag, "_tile_seq_len"}, tq.size(), NT);
        for (int t = 0; t < NT && t < tq.size(); t++) chk({tag, "_tile_seq"}, tq[t], t);
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; bit_i = 1'b0; bit_valid = 1'b0;
        clear_rec();
        step();
        chk_on = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_cfg", cfg_bits, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bit_ready, 0);
        chk("rst_tile", tile_idx, 0);

        // Full-rate session; start raised in the done cycle must be ignored.
        frames = '{18'h3F000, 18'h00E07, 18'h2A2A2, 18'h15555};
        clear_rec();
        run_session(1'b0, -1, -1);
        wait_done(1'b1);
        step();
        chk("s1_done_count", n_done, 1);
        chk("s1_latency", done_cyc - first_cyc, SESSION_CYC);
        chk("s1_start_on_done_busy", busy, 0);
        check_frames("s1");

        // Stalled source with a stray start during tile 2.
        frames = '{18'h12345, 18'h3FFFF, 18'h00000, 18'h2C0D3};
        clear_rec();
        run_session(1'b1, 2, -1);
        wait_done(1'b0);
        chk("s2_done_count", n_done, 1);
        check_frames("s2");

        // Reset during the tile-1 write window, then a clean reload.
        frames = '{18'h0AAAA, 18'h35A5A, 18'h00003, 18'h30000};
        clear_rec();
        start = 1'b1;
        step();
        start = 1'b0;
        send_bits({1'b0, frames[0]} << PAR | (PAR ? FW'(^frames[0]) : 0), NB, 1'b0, 1'b0);
        send_bits({1'b0, frames[1]} << PAR | (PAR ? FW'(^frames[1]) : 0), NB, 1'b0, 1'b0);
        for (k = 0; k < 20; k++) begin
            if (wr_en[1]) break;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s3_rst_wr_en", wr_en, 0);
        chk("s3_rst_busy", busy, 0);
        chk("s3_rst_tile", tile_idx, 0);
        chk("s3_tile1_partial", rec_cnt[1], 1);
        frames = '{18'h1F0F0, 18'h20F0F, 18'h3C3C3, 18'h03C3C};
        clear_rec();
        run_session(1'b0, -1, -1);
        wait_done(1'b0);
        check_frames("s3");

`ifdef CFG_PARITY_EN
        // Bad parity on tile 2 aborts the session with err set.
        frames = '{18'h11111, 18'h22222, 18'h00001, 18'h33333};
        clear_rec();
        run_session(1'b0, -1, 2);
        for (int i = 0; i < 8; i++) step();
        chk("s4_err", err, 1);
        chk("s4_busy", busy, 0);
        chk("s4_no_wr2", rec_cnt[2], 0);
        chk("s4_no_done", n_done, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("s4_err_cleared", err, 0);
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before 400000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cblock_cfg_loader.md
Name: cblock_cfg_loader

Overview:
- Configuration controller for the connection-block fabric.
- Accepts a bit-serial bitstream over a valid/ready handshake and assembles one FRAME_W-bit frame per tile.
- Drives the shared cfg_bits bus and a one-hot high-enable wr_en per tile, sequenced so the tile's level-sensitive latches capture stable data.
- Sits between the bitstream source (JTAG/SPI bridge or testbench) and the array of connection blocks.

Parameters:
- FRAME_W, 18: configuration bits per tile (6 dots x 3 bits).
- NUM_TILES, 4: number of tiles loaded per session; tile 0 is loaded first.
- WR_CYCLES, 2: cycles wr_en stays high per frame; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load session.
- bit_i  in  1  serial config bit, MSB of each frame first.
- bit_valid  in  1  bit_i is valid this cycle.
- bit_ready  out  1  loader accepts a bit this cycle.
- cfg_bits  out  FRAME_W  frame data bus shared by all tiles.
- wr_en  out  NUM_TILES  one-hot latch enable, bit i goes to tile i.
- tile_idx  out  $clog2(NUM_TILES)  tile currently being loaded.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse when the last frame is written.
- err  out  1  sticky frame error; cleared by start or rst.

Behaviour:
- Reset values: all outputs 0, state IDLE, bit and write counters 0.
- Reset mid-session: wr_en drops to 0 on the next edge. Tile latches keep whatever they already captured, and the session is abandoned.
- A bit is accepted only on a cycle where bit_valid && bit_ready. bit_ready is 1 only in SHIFT. bit_valid with bit_ready low is ignored and the bit is not consumed.
- FSM states:
  - IDLE: on start, go to SHIFT, set busy=1, clear err, tile_idx=0, bit_cnt=0.
  - SHIFT: each accepted bit does shift_reg <= {shift_reg[FRAME_W-2:0], bit_i}. When the FRAME_W-th bit is accepted, go to SETUP.
  - SETUP: exactly 1 cycle. cfg_bits <= shift_reg, wr_en all 0.
  - WRITE: WR_CYCLES cycles. wr_en[tile_idx]=1, all other wr_en bits 0, cfg_bits held.
  - HOLD: exactly 1 cycle. wr_en=0, cfg_bits still held, so data is stable past the latch closing.
    - If tile_idx==NUM_TILES-1: go to IDLE, pulse done, set busy=0.
    - Otherwise: tile_idx++, bit_cnt=0, go to SHIFT.
- cfg_bits changes only on entry to SETUP and never while any wr_en bit is high.
- At most one wr_en bit is ever high.
- start while busy is ignored. start asserted in the same cycle done pulses is also ignored; a new session needs start in IDLE.
- Frame write latency: the first wr_en-high cycle is 2 cycles after the cycle that accepted the last bit. A full session, with bits on every cycle, takes NUM_TILES*(FRAME_W+2+WR_CYCLES) cycles from the first bit to done.
- The bit_i source may stall arbitrarily (bit_valid low); the loader waits in SHIFT with no timeout.

Optional Feature:
- Macro: CFG_PARITY_EN
- Defined:
  - Each frame is followed by one even-parity bit. SHIFT accepts FRAME_W+1 bits, and the parity is checked over the frame bits plus the parity bit.
  - Mismatch: skip SETUP and WRITE (no wr_en for that tile), set err=1, go to IDLE with busy=0. done is not pulsed.
  - Match: proceed to SETUP as normal.
- Undefined: no parity bit is consumed and err stays 0.

Decomposition:
- Package cblock_cfg_pkg holds:
  - the state enum (IDLE, SHIFT, SETUP, WRITE, HOLD);
  - the localparam CB_FRAME_W=18;
  - field offsets for the Sblock-side bit groups (V=17:12, LU=11:9, DR=8:6, UR=5:3, LD=2:0) for bitstream tooling.
- One sub-module, cfg_shift_reg, holds the serial-in frame register, the bit counter and the optional parity accumulator. The FSM and wr_en decode stay in the top module.

Test Plan:
- Single session, NUM_TILES=4, bits every cycle; frames 18'h3F000, 18'h00E07, 18'h2A2A2, 18'h15555 -> each tile's wr_en goes high for exactly 2 cycles with the matching cfg_bits; done pulses once at cycle 4*22; busy falls together with done.
- Stalled source: bit_valid toggles 1-0-1-0 -> frame written only after 18 accepted bits; cfg_bits is never modified while any wr_en is high (assertion).
- start pulsed mid-session at tile 2 -> ignored; tile_idx sequence stays 0,1,2,3.
- rst asserted during WRITE for tile 1 -> next cycle wr_en=0, busy=0, tile_idx=0; a following start reloads from tile 0.
- CFG_PARITY_EN: tile 2 frame 18'h00001 with parity bit 0 -> no wr_en[2] pulse, err=1, done never pulses; the next start clears err.
- One-hot check across all scenarios: $countones(wr_en)<=1 every cycle; wr_en is low during every SETUP and HOLD cycle.
